dcache_assoc_nb: RTL and testbench
==================================

Name: dcache_assoc_nb

Overview:
- Parametrised successor to the single-port direct-mapped data cache: N-way set-associative, non-blocking, with an MSHR table that tracks outstanding line fills.
- Sits between the load/store unit and the memory arbiter.
- Serves one load lookup and one store update per cycle.
- Issues at most one memory line request per cycle and absorbs tagged memory responses.

Parameters:
- SETS, 8, number of sets (power of 2, >=2)
- WAYS, 2, associativity (power of 2, >=1)
- MSHR_DEPTH, 4, outstanding miss entries (>=1)
- ADDR_W, 32, byte address width; block = 8 bytes, word = 4 bytes, offset = 3 bits
- TAG_W, 4, memory transaction tag width; tag 0 means "no transaction"

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- rd_valid  in  1  load lookup request
- rd_addr  in  ADDR_W  load address, word aligned
- rd_hit  out  1  load hit this cycle
- rd_data  out  32  hit word; 0 when !rd_hit
- wr_valid  in  1  store update request
- wr_addr  in  ADDR_W  store address, word aligned
- wr_data  in  32  store word
- wr_hit  out  1  store found its line and updated it
- mshr_full  out  1  no free MSHR entry
- mem_req_valid  out  1  line request to arbiter
- mem_req_addr  out  ADDR_W  block-aligned request address (low 3 bits 0)
- mem_req_accepted  in  1  arbiter granted the request this cycle
- current_req_tag  in  TAG_W  tag memory assigned to the granted request
- mem_data  in  64  returning block
- mem_data_tag  in  TAG_W  tag of mem_data; 0 = none

Behaviour:
- Reset:
  - all line valid bits, MSHR entries and replacement pointers are cleared.
  - All outputs are 0 in the cycle after reset; mshr_full=0.
- Lookup: index = addr[3+:log2(SETS)]; tag = remaining upper bits. Tag compare across all ways is combinational.
- Load hit: rd_hit=1 and rd_data = selected word in the same cycle (0-cycle latency).
- Load miss (rd_valid and no hit):
  - If a valid MSHR entry already holds the block, nothing is allocated (merge).
  - Else, if an entry is free, the lowest-index free entry is allocated in state ISSUE at the clock edge.
  - Else nothing is allocated; the requester retries.
- Store: on hit, the word is written at the clock edge and wr_hit=1. On miss, wr_hit=0 and the store has no effect; there is no write-allocate and no memory write from this block.
- MSHR entry FSM: FREE -> ISSUE -> WAIT -> FREE.
  - ISSUE: the oldest ISSUE entry (allocation order) drives mem_req_valid=1 and mem_req_addr.
  - On mem_req_accepted with current_req_tag!=0, the entry captures the tag and moves to WAIT.
  - On mem_req_accepted with current_req_tag==0, the entry stays in ISSUE and retries next cycle.
- Fill: when mem_data_tag!=0 matches a WAIT entry's tag, at the clock edge:
  - the block is written into the victim way of its set, with valid=1;
  - the per-set round-robin pointer advances mod WAYS;
  - the entry returns to FREE.
- Victim choice: the first invalid way (lowest index) if any; otherwise the round-robin pointer's way.
- An unmatched nonzero mem_data_tag is ignored.
- mshr_full = no FREE entry. A miss that coincides with a freeing fill still sees the pre-edge full state and is not allocated.
- Same-cycle interactions:
  - Fill and load to the same block: the load sees pre-fill contents, i.e. a miss that merges with the entry being freed, so no allocation.
  - Fill and store to the same block: the fill is applied first, then the store word overrides it. wr_hit=0 (lookup is pre-fill), but the store data is still merged into the filled line.
  - Allocation and issue in the same cycle: a new entry becomes eligible to issue the following cycle.
- Reset asserted mid-operation discards all entries and in-flight tags. Later responses carrying stale tags are ignored.

Optional Feature:
- DCACHE_FILL_BYPASS_EN
- Defined: when a fill matches a load's block in the same cycle, rd_hit=1 and rd_data is taken from mem_data. No merge or allocation occurs.
- Undefined: the behaviour is as specified above (load misses that cycle).

Test Plan:
- Reset at reset=0, then load 0x100 -> rd_hit=0, mem_req_valid=1 and mem_req_addr=0x100 the next cycle; accept with tag 3; mem_data=0x1111_2222_3333_4444 with tag 3; load 0x104 -> rd_hit=1, rd_data=0x1111_2222.
- Fill 0x100; store 0x100 with 0xDEADBEEF -> wr_hit=1; load 0x100 -> 0xDEADBEEF. Store 0x900 (miss) -> wr_hit=0, no MSHR allocated.
- SETS=8, WAYS=2: fill 0x000, 0x040, 0x080 (all set 0) -> the third fill evicts way 0; load 0x000 misses and load 0x040 hits.
- MSHR_DEPTH=4: misses to 4 distinct blocks -> mshr_full=1; a fifth miss allocates nothing. A repeat miss to the first block does not allocate. Grant with current_req_tag=0 -> the same address is re-requested the next cycle.
- Responses returned out of order (tags 2 then 1) -> both lines valid; mem_data_tag=7 with no match -> no state change. Reset=0 mid-WAIT, then the stale tag returns -> ignored, all loads miss.

Source files
------------

// File: rtl/dcache_assoc_nb_if.sv
// Load/store-unit and memory-arbiter signal bundle for dcache_assoc_nb.
// The cache uses the slave modport; the LSU/arbiter side uses master.
interface dcache_assoc_nb_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4
) ();
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic [31:0]       rd_data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_hit;
    logic              mshr_full;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_accepted;
    logic [TAG_W-1:0]  current_req_tag;
    logic [63:0]       mem_data;
    logic [TAG_W-1:0]  mem_data_tag;

    // Request handshake: mem_req_valid/mem_req_addr hold until a cycle with
    // mem_req_accepted=1 and a nonzero current_req_tag; a zero tag means the
    // grant carried no transaction and the same request is presented again.
    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  mem_req_accepted, current_req_tag, mem_data, mem_data_tag,
        output rd_hit, rd_data, wr_hit, mshr_full, mem_req_valid, mem_req_addr
    );

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output mem_req_accepted, current_req_tag, mem_data, mem_data_tag,
        input  rd_hit, rd_data, wr_hit, mshr_full, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/dcache_assoc_nb.sv
// N-way set-associative non-blocking data cache with an MSHR table for line fills.
// Optional macro DCACHE_FILL_BYPASS_EN forwards a same-cycle fill to a matching load.
module dcache_assoc_nb #(
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int MSHR_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    dcache_assoc_nb_if.slave        bus,
    output logic [2*MSHR_DEPTH-1:0] mshr_state_dbg
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int BLK_W  = ADDR_W - 3;
    localparam int LTAG_W = BLK_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int MI_W   = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
    localparam int CNT_W  = $clog2(MSHR_DEPTH + 1);

    typedef enum logic [1:0] {M_FREE = 2'd0, M_ISSUE = 2'd1, M_WAIT = 2'd2} mshr_state_e;

    logic              line_valid [SETS][WAYS];
    logic [LTAG_W-1:0] line_tag   [SETS][WAYS];
    logic [63:0]       line_data  [SETS][WAYS];
    logic [WAY_W-1:0]  rr_ptr     [SETS];

    mshr_state_e       m_state   [MSHR_DEPTH];
    mshr_state_e       m_state_d [MSHR_DEPTH];
    logic [BLK_W-1:0]  m_blk     [MSHR_DEPTH];
    logic [TAG_W-1:0]  m_tag     [MSHR_DEPTH];

    // Entries waiting to issue, oldest at slot 0; only the head ever leaves ISSUE.
    logic [MI_W-1:0]   iq   [MSHR_DEPTH];
    logic [MI_W-1:0]   iq_d [MSHR_DEPTH];
    logic [CNT_W-1:0]  iq_cnt, iq_cnt_d;

    logic [BLK_W-1:0]  rd_blk, wr_blk, fill_blk;
    logic [IDX_W-1:0]  rd_idx, wr_idx, fill_idx;
    logic              lk_hit, st_hit, fill_hit, vict_found, merge, free_found, byp;
    logic [WAY_W-1:0]  lk_way, st_way, vict_way;
    logic [MI_W-1:0]   fill_ent, free_ent, iss_ent;
    logic              iss_valid, accept, alloc, wr_do;
    logic [63:0]       fill_line;
    logic [31:0]       lk_word, byp_word;

    assign rd_blk   = bus.rd_addr[ADDR_W-1:3];
    assign wr_blk   = bus.wr_addr[ADDR_W-1:3];
    assign rd_idx   = rd_blk[IDX_W-1:0];
    assign wr_idx   = wr_blk[IDX_W-1:0];
    assign fill_blk = m_blk[fill_ent];
    assign fill_idx = fill_blk[IDX_W-1:0];

    always_comb begin
        lk_hit = 1'b0; lk_way = '0; st_hit = 1'b0; st_way = '0;
        fill_hit = 1'b0; fill_ent = '0; merge = 1'b0; free_found = 1'b0; free_ent = '0;
        vict_found = 1'b0; vict_way = rr_ptr[fill_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && line_valid[rd_idx][w] && line_tag[rd_idx][w] == rd_blk[BLK_W-1:IDX_W]) begin
                lk_hit = 1'b1; lk_way = WAY_W'(w);
            end
            if (!st_hit && line_valid[wr_idx][w] && line_tag[wr_idx][w] == wr_blk[BLK_W-1:IDX_W]) begin
                st_hit = 1'b1; st_way = WAY_W'(w);
            end
            if (!vict_found && !line_valid[fill_idx][w]) begin
                vict_found = 1'b1; vict_way = WAY_W'(w);
            end
        end
        for (int e = 0; e < MSHR_DEPTH; e++) begin
            if (!fill_hit && m_state[e] == M_WAIT && bus.mem_data_tag != '0 && m_tag[e] == bus.mem_data_tag) begin
                fill_hit = 1'b1; fill_ent = MI_W'(e);
            end
            if (m_state[e] != M_FREE && m_blk[e] == rd_blk) merge = 1'b1;
            if (!free_found && m_state[e] == M_FREE) begin
                free_found = 1'b1; free_ent = MI_W'(e);
            end
        end
    end

`ifdef DCACHE_FILL_BYPASS_EN
    assign byp = bus.rd_valid && fill_hit && fill_blk == rd_blk;
`else
    assign byp = 1'b0;
`endif

    assign lk_word  = bus.rd_addr[2] ? line_data[rd_idx][lk_way][63:32] : line_data[rd_idx][lk_way][31:0];
    assign byp_word = bus.rd_addr[2] ? bus.mem_data[63:32] : bus.mem_data[31:0];

    assign bus.rd_hit    = bus.rd_valid && (lk_hit || byp);
    assign bus.rd_data   = !bus.rd_valid ? 32'd0 : byp ? byp_word : lk_hit ? lk_word : 32'd0;
    assign bus.wr_hit    = bus.wr_valid && st_hit;
    assign bus.mshr_full = !free_found;

    assign iss_valid         = iq_cnt != '0;
    assign iss_ent           = iq[0];
    assign bus.mem_req_valid = iss_valid;
    assign bus.mem_req_addr  = iss_valid ? {m_blk[iss_ent], 3'b000} : '0;

    assign accept = iss_valid && bus.mem_req_accepted && bus.current_req_tag != '0;
    assign alloc  = bus.rd_valid && !lk_hit && !byp && !merge && free_found;
    // A store hitting the way the fill is about to evict has lost its line.
    assign wr_do  = bus.wr_hit && !(fill_hit && fill_idx == wr_idx && vict_way == st_way);

    always_comb begin
        fill_line = bus.mem_data;
        if (bus.wr_valid && wr_blk == fill_blk) begin
            if (bus.wr_addr[2]) fill_line[63:32] = bus.wr_data;
            else                fill_line[31:0]  = bus.wr_data;
        end
    end

    always_comb begin
        for (int e = 0; e < MSHR_DEPTH; e++) m_state_d[e] = m_state[e];
        if (alloc)    m_state_d[free_ent] = M_ISSUE;
        if (accept)   m_state_d[iss_ent]  = M_WAIT;
        if (fill_hit) m_state_d[fill_ent] = M_FREE;

        iq_d     = iq;
        iq_cnt_d = iq_cnt;
        if (accept) begin
            for (int i = 0; i < MSHR_DEPTH - 1; i++) iq_d[i] = iq[i+1];
            iq_cnt_d = iq_cnt_d - CNT_W'(1);
        end
        if (alloc) begin
            for (int i = 0; i < MSHR_DEPTH; i++)
                if (CNT_W'(i) == iq_cnt_d) iq_d[i] = free_ent;
            iq_cnt_d = iq_cnt_d + CNT_W'(1);
        end
    end

    always_comb begin
        mshr_state_dbg = '0;
        for (int e = 0; e < MSHR_DEPTH; e++) mshr_state_dbg[2*e +: 2] = m_state[e];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int e = 0; e < MSHR_DEPTH; e++) m_state[e] <= M_FREE;
            iq_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) line_valid[s][w] <= 1'b0;
            end
        end else begin
            for (int e = 0; e < MSHR_DEPTH; e++) m_state[e] <= m_state_d[e];
            iq_cnt <= iq_cnt_d;
            if (fill_hit) begin
                line_valid[fill_idx][vict_way] <= 1'b1;
                line_tag[fill_idx][vict_way]   <= fill_blk[BLK_W-1:IDX_W];
                rr_ptr[fill_idx] <= (WAYS > 1) ? rr_ptr[fill_idx] + WAY_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        iq <= iq_d;
        if (alloc)  m_blk[free_ent] <= rd_blk;
        if (accept) m_tag[iss_ent]  <= bus.current_req_tag;
        if (fill_hit) line_data[fill_idx][vict_way] <= fill_line;
        if (wr_do) begin
            if (bus.wr_addr[2]) line_data[wr_idx][st_way][63:32] <= bus.wr_data;
            else                line_data[wr_idx][st_way][31:0]  <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_dcache_assoc_nb.sv
// Directed bench for dcache_assoc_nb (SETS=8, WAYS=2, MSHR_DEPTH=4): lookup, fill,
// eviction, MSHR merge/full, tag-0 retry, out-of-order fills and stale tags.
module tb_dcache_assoc_nb;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] mshr_state_dbg;
    int         n_checks = 0;
    int         n_fail   = 0;

    dcache_assoc_nb_if #(.ADDR_W(32), .TAG_W(4)) bus ();

    dcache_assoc_nb #(.SETS(8), .WAYS(2), .MSHR_DEPTH(4), .ADDR_W(32), .TAG_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .mshr_state_dbg (mshr_state_dbg)
    );

    always #50 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rd_valid = 1'b0; bus.rd_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.mem_req_accepted = 1'b0; bus.current_req_tag = '0;
        bus.mem_data = '0; bus.mem_data_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    // Combinational probe only: never crosses a clock edge, so no allocation.
    task automatic load_check(input string tag, input logic [31:0] a, input logic hit, input logic [31:0] d);
        bus.rd_valid = 1'b1; bus.rd_addr = a;
        #1;
        check({tag, "_hit"}, 64'(bus.rd_hit), 64'(hit));
        check({tag, "_data"}, 64'(bus.rd_data), 64'(d));
        bus.rd_valid = 1'b0;
        #1;
    endtask

    task automatic miss_fill(input logic [31:0] a, input logic [63:0] d, input logic [3:0] t);
        bus.rd_valid = 1'b1; bus.rd_addr = a;
        step();
        bus.rd_valid = 1'b0;
        bus.mem_req_accepted = 1'b1; bus.current_req_tag = t;
        step();
        bus.mem_req_accepted = 1'b0; bus.current_req_tag = '0;
        bus.mem_data = d; bus.mem_data_tag = t;
        step();
        idle();
        #1;
    endtask

    task automatic issue_miss(input logic [31:0] a);
        bus.rd_valid = 1'b1; bus.rd_addr = a;
        step();
        bus.rd_valid = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_rd_hit", 64'(bus.rd_hit), 64'd0);
        check("rst_wr_hit", 64'(bus.wr_hit), 64'd0);
        check("rst_full", 64'(bus.mshr_full), 64'd0);
        check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_req_addr", 64'(bus.mem_req_addr), 64'd0);
        check("rst_dbg", 64'(mshr_state_dbg), 64'h00);

        // First miss, issue, grant, fill
        bus.rd_valid = 1'b1; bus.rd_addr = 32'h100;
        #1;
        check("miss_rd_hit", 64'(bus.rd_hit), 64'd0);
        check("miss_rd_data", 64'(bus.rd_data), 64'd0);
        check("alloc_cycle_no_req", 64'(bus.mem_req_valid), 64'd0);
        step();
        bus.rd_valid = 1'b0;
        #1;
        check("req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("req_addr", 64'(bus.mem_req_addr), 64'h100);
        bus.mem_req_accepted = 1'b1; bus.current_req_tag = 4'd3;
        step();
        idle();
        #1;
        check("granted_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("granted_dbg", 64'(mshr_state_dbg), 64'h02);
        bus.mem_data = 64'h1111_2222_3333_4444; bus.mem_data_tag = 4'd3;
        step();
        idle();
        #1;
        check("filled_dbg", 64'(mshr_state_dbg), 64'h00);
        load_check("ld_104", 32'h104, 1'b1, 32'h1111_2222);
        load_check("ld_100", 32'h100, 1'b1, 32'h3333_4444);

        // Store hit and store miss
        bus.wr_valid = 1'b1; bus.wr_addr = 32'h100; bus.wr_data = 32'hDEAD_BEEF;
        #1;
        check("st_hit", 64'(bus.wr_hit), 64'd1);
        step();
        idle();
        #1;
        load_check("ld_after_st", 32'h100, 1'b1, 32'hDEAD_BEEF);
        load_check("ld_other_word", 32'h104, 1'b1, 32'h1111_2222);
        bus.wr_valid = 1'b1; bus.wr_addr = 32'h900; bus.wr_data = 32'h5555_AAAA;
        #1;
        check("st_miss", 64'(bus.wr_hit), 64'd0);
        step();
        idle();
        #1;
        check("st_miss_no_req", 64'(bus.mem_req_valid), 64'd0);
        check("st_miss_dbg", 64'(mshr_state_dbg), 64'h00);
        load_check("st_miss_no_line", 32'h900, 1'b0, 32'd0);

        // Eviction in set 0: ways fill 0,1 then round-robin evicts way 0
        do_reset();
        load_check("rst_clears_line", 32'h100, 1'b0, 32'd0);
        miss_fill(32'h000, 64'hA0A0_A0A0_A1A1_A1A1, 4'd1);
        miss_fill(32'h040, 64'hB0B0_B0B0_B1B1_B1B1, 4'd2);
        miss_fill(32'h080, 64'hC0C0_C0C0_C1C1_C1C1, 4'd3);
        load_check("evicted_000", 32'h000, 1'b0, 32'd0);
        load_check("kept_044", 32'h044, 1'b1, 32'hB0B0_B0B0);
        load_check("new_080", 32'h080, 1'b1, 32'hC1C1_C1C1);

        // MSHR merge, fill-up and full
        do_reset();
        issue_miss(32'h200);
        check("one_alloc", 64'(mshr_state_dbg), 64'h01);
        issue_miss(32'h204);
        check("merge_same_block", 64'(mshr_state_dbg), 64'h01);
        issue_miss(32'h300);
        issue_miss(32'h400);
        check("three_alloc", 64'(mshr_state_dbg), 64'h15);
        check("not_full", 64'(bus.mshr_full), 64'd0);
        issue_miss(32'h500);
        check("full", 64'(bus.mshr_full), 64'd1);
        check("four_alloc", 64'(mshr_state_dbg), 64'h55);
        issue_miss(32'h600);
        check("fifth_no_alloc", 64'(mshr_state_dbg), 64'h55);
        check("oldest_req", 64'(bus.mem_req_addr), 64'h200);

        // Grant with tag 0 retries the same request
        bus.mem_req_accepted = 1'b1; bus.current_req_tag = 4'd0;
        step();
        #1;
        check("tag0_retry_valid", 64'(bus.mem_req_valid), 64'd1);
        check("tag0_retry_addr", 64'(bus.mem_req_addr), 64'h200);
        check("tag0_dbg", 64'(mshr_state_dbg), 64'h55);
        bus.current_req_tag = 4'd1;
        step();
        #1;
        check("next_req_addr", 64'(bus.mem_req_addr), 64'h300);
        check("grant1_dbg", 64'(mshr_state_dbg), 64'h56);
        bus.current_req_tag = 4'd2;
        step();
        idle();
        #1;
        check("req_after_2_grants", 64'(bus.mem_req_addr), 64'h400);
        check("grant2_dbg", 64'(mshr_state_dbg), 64'h5A);

        // Out-of-order return, with a miss during the freeing fill
        bus.mem_data = 64'h2222_0000_2222_1111; bus.mem_data_tag = 4'd2;
        bus.rd_valid = 1'b1; bus.rd_addr = 32'h600;
        step();
        idle();
        #1;
        check("free_fill_no_alloc", 64'(mshr_state_dbg), 64'h52);
        check("not_full_after_fill", 64'(bus.mshr_full), 64'd0);
        load_check("ooo_300", 32'h300, 1'b1, 32'h2222_1111);
        bus.mem_data = 64'h1111_0000_1111_2222; bus.mem_data_tag = 4'd1;
        step();
        idle();
        #1;
        check("both_free_dbg", 64'(mshr_state_dbg), 64'h50);
        load_check("ooo_204", 32'h204, 1'b1, 32'h1111_0000);
        load_check("ooo_300_kept", 32'h304, 1'b1, 32'h2222_0000);

        // Unmatched tag changes nothing
        bus.mem_data = 64'hFFFF_FFFF_FFFF_FFFF; bus.mem_data_tag = 4'd7;
        step();
        idle();
        #1;
        check("tag7_dbg", 64'(mshr_state_dbg), 64'h50);
        load_check("tag7_200", 32'h200, 1'b1, 32'h1111_2222);

        // Fill and store to the same block: store word overrides fill data
        bus.mem_req_accepted = 1'b1; bus.current_req_tag = 4'd4;
        step();
        idle();
        #1;
        check("grant4_dbg", 64'(mshr_state_dbg), 64'h60);
        bus.mem_data = 64'hAAAA_BBBB_CCCC_DDDD; bus.mem_data_tag = 4'd4;
        bus.wr_valid = 1'b1; bus.wr_addr = 32'h404; bus.wr_data = 32'h1234_5678;
        #1;
        check("fill_st_wr_hit", 64'(bus.wr_hit), 64'd0);
        step();
        idle();
        #1;
        load_check("fill_st_404", 32'h404, 1'b1, 32'h1234_5678);
        load_check("fill_st_400", 32'h400, 1'b1, 32'hCCCC_DDDD);
        load_check("rr_evict_300", 32'h300, 1'b0, 32'd0);
        load_check("rr_keep_200", 32'h200, 1'b1, 32'h1111_2222);

        // Fill and load to the same block
        bus.mem_req_accepted = 1'b1; bus.current_req_tag = 4'd5;
        step();
        idle();
        bus.mem_data = 64'h5555_6666_7777_8888; bus.mem_data_tag = 4'd5;
        bus.rd_valid = 1'b1; bus.rd_addr = 32'h500;
        #1;
`ifdef DCACHE_FILL_BYPASS_EN
        check("fill_ld_hit", 64'(bus.rd_hit), 64'd1);
        check("fill_ld_data", 64'(bus.rd_data), 64'h7777_8888);
`else
        check("fill_ld_hit", 64'(bus.rd_hit), 64'd0);
        check("fill_ld_data", 64'(bus.rd_data), 64'd0);
`endif
        step();
        idle();
        #1;
        check("fill_ld_no_alloc", 64'(mshr_state_dbg), 64'h00);
        load_check("fill_ld_after", 32'h504, 1'b1, 32'h5555_6666);

        // Reset mid-WAIT, then the stale tag returns
        issue_miss(32'h700);
        bus.mem_req_accepted = 1'b1; bus.current_req_tag = 4'd6;
        step();
        idle();
        #1;
        check("wait6_dbg", 64'(mshr_state_dbg), 64'h02);
        do_reset();
        bus.mem_data = 64'h6666_6666_6666_6666; bus.mem_data_tag = 4'd6;
        step();
        idle();
        #1;
        check("stale_dbg", 64'(mshr_state_dbg), 64'h00);
        load_check("stale_700", 32'h700, 1'b0, 32'd0);
        load_check("stale_200", 32'h200, 1'b0, 32'd0);
        load_check("stale_400", 32'h400, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
